// File: rtl/mod_pkg.sv
// rtl/mod_pkg.sv - shared width, control encodings and controller states for the MOD unit
package mod_pkg;

  localparam int MOD_WIDTH = 32;

  // Control strobes are grouped as {we, s}
  localparam logic [1:0] CTL_LOAD = 2'b10;
  localparam logic [1:0] CTL_SUB  = 2'b11;

  typedef enum logic [1:0] {
    START  = 2'd0,
    SUB    = 2'd1,
    RESULT = 2'd2
  } mod_state_e;

  function automatic logic [1:0] ctl_of(input logic we, input logic s);
    return {we, s};
  endfunction

endpackage

// File: rtl/mod_sub_cmp.sv
// rtl/mod_sub_cmp.sv - combinational subtract/compare shared by MOD datapath and ALU compare path
module mod_sub_cmp
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             ge,
  output logic             b_zero
);

  assign diff   = a - b;
  assign ge     = (a >= b);
  assign b_zero = (b == '0);

endmodule

// File: rtl/mod_dp.sv
// rtl/mod_dp.sv - MOD datapath: A mod B by repeated subtraction; MOD_QUOTIENT_EN adds quotient output
module mod_dp
  import mod_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             we,
  input  logic             s,
  input  logic             re,
  output logic             x,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             div_zero
`ifdef MOD_QUOTIENT_EN
  ,
  output logic [WIDTH-1:0] quotient
`endif
);

  logic [WIDTH-1:0] temp_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic             result_valid_r;
  logic             div_zero_r;

  logic [WIDTH-1:0] diff;
  logic             ge;
  logic             b_zero;
  logic [1:0]       ctl;

  mod_sub_cmp #(.WIDTH(WIDTH)) u_sub_cmp (
    .a      (temp_r),
    .b      (b_r),
    .diff   (diff),
    .ge     (ge),
    .b_zero (b_zero)
  );

  assign ctl = ctl_of(we, s);

  // b_r == 0 counts as "done" so the controller never spins on a zero divisor
  assign x            = ~ge | b_zero;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign div_zero     = div_zero_r;

`ifdef MOD_QUOTIENT_EN
  logic [WIDTH-1:0] qcount_r;
  logic [WIDTH-1:0] quotient_r;

  assign quotient = quotient_r;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      qcount_r   <= '0;
      quotient_r <= '0;
    end else if (ctl == CTL_LOAD) begin
      qcount_r <= '0;
    end else if (ctl == CTL_SUB) begin
      if (ge && !b_zero && qcount_r != '1) begin
        qcount_r <= qcount_r + WIDTH'(1);
      end
    end else if (re && !result_valid_r) begin
      quotient_r <= qcount_r;
    end
  end
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      temp_r         <= '0;
      b_r            <= '0;
      result_r       <= '0;
      result_valid_r <= 1'b0;
      div_zero_r     <= 1'b0;
    end else if (ctl == CTL_LOAD) begin
      temp_r         <= A;
      b_r            <= B;
      div_zero_r     <= (B == '0);
      result_valid_r <= 1'b0;
    end else if (ctl == CTL_SUB) begin
      // Holding when temp_r < b_r makes surplus subtract strobes harmless
      if (ge && !b_zero) begin
        temp_r <= diff;
      end
    end else if (re && !result_valid_r) begin
      result_r       <= temp_r;
      result_valid_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mod_dp.sv
// tb/tb_mod_dp.sv - self-checking bench for mod_dp (WIDTH=8), optional MOD_QUOTIENT_EN checks
module tb_mod_dp;
  import mod_pkg::*;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         reset;
  logic [W-1:0] A, B;
  logic         we, s, re;
  logic         x;
  logic [W-1:0] result;
  logic         result_valid;
  logic         div_zero;
`ifdef MOD_QUOTIENT_EN
  logic [W-1:0] quotient;
`endif

  mod_dp #(.WIDTH(W)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .A            (A),
    .B            (B),
    .we           (we),
    .s            (s),
    .re           (re),
    .x            (x),
    .result       (result),
    .result_valid (result_valid),
    .div_zero     (div_zero)
`ifdef MOD_QUOTIENT_EN
    ,
    .quotient     (quotient)
`endif
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] rem;
    logic [W-1:0] quo;
    logic         dz;
  } vec_t;

  vec_t vecs[6];

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b, input logic with_re);
    @(negedge CLK);
    we = 1'b1; s = 1'b0; re = with_re; A = a; B = b;
    @(negedge CLK);
    we = 1'b0; s = 1'b0; re = 1'b0;
  endtask

  task automatic sub_n(input int n);
    for (int i = 0; i < n; i++) begin
      we = 1'b1; s = 1'b1; re = 1'b0;
      @(negedge CLK);
    end
    we = 1'b0; s = 1'b0;
  endtask

  task automatic capture();
    re = 1'b1;
    @(negedge CLK);
    re = 1'b0;
  endtask

  // Drives a Moore controller (SUB while x=0, one transition cycle, then RESULT)
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] rem, input logic [W-1:0] quo, input logic dz);
    mod_state_e st;
    int         cyc;
    int         xlow;
    bit         done;
    load(a, b, 1'b0);
    st   = SUB;
    xlow = 0;
    done = 0;
    for (cyc = 0; cyc < 600; cyc++) begin
      if (result_valid) begin
        done = 1;
        break;
      end
      A = W'($urandom);
      B = W'($urandom);
      if (st == SUB) begin
        we = 1'b1; s = 1'b1; re = 1'b0;
        if (x) st = RESULT;
        else xlow++;
      end else begin
        we = 1'b0; s = 1'b0; re = 1'b1;
      end
      @(negedge CLK);
    end
    we = 1'b0; s = 1'b0; re = 1'b0;
    if (!done) $display("FAIL %s timeout: got no result_valid expected result_valid within 600 cycles", tag);
    check({tag, " latency"}, done ? cyc : 999, quo + 2);
    check({tag, " x_low_cycles"}, xlow, quo);
    check({tag, " result"}, result, rem);
    check({tag, " result_valid"}, result_valid, 1);
    check({tag, " div_zero"}, div_zero, dz);
`ifdef MOD_QUOTIENT_EN
    check({tag, " quotient"}, quotient, quo);
`endif
    capture();
    capture();
    check({tag, " result_hold"}, result, rem);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 8'd3,   b: 8'd5, rem: 8'd3,  quo: 8'd0,   dz: 1'b0};
    vecs[1] = '{a: 8'd42,  b: 8'd0, rem: 8'd42, quo: 8'd0,   dz: 1'b1};
    vecs[2] = '{a: 8'd20,  b: 8'd5, rem: 8'd0,  quo: 8'd4,   dz: 1'b0};
    vecs[3] = '{a: 8'd255, b: 8'd1, rem: 8'd0,  quo: 8'd255, dz: 1'b0};
    vecs[4] = '{a: 8'd9,   b: 8'd4, rem: 8'd1,  quo: 8'd2,   dz: 1'b0};
    vecs[5] = '{a: 8'd17,  b: 8'd5, rem: 8'd2,  quo: 8'd3,   dz: 1'b0};

    reset = 1'b1; we = 1'b0; s = 1'b0; re = 1'b0; A = '0; B = '0;
    #2;
    check("reset result", result, 0);
    check("reset result_valid", result_valid, 0);
    check("reset div_zero", div_zero, 0);
    check("reset x", x, 1);
`ifdef MOD_QUOTIENT_EN
    check("reset quotient", quotient, 0);
`endif
    @(negedge CLK);
    reset = 1'b0;

    // Divide by zero with surplus subtract strobes
    load(8'd42, 8'd0, 1'b0);
    check("dz x_after_load", x, 1);
    check("dz div_zero", div_zero, 1);
    sub_n(3);
    check("dz x_after_subs", x, 1);
    capture();
    check("dz result", result, 42);
    check("dz result_valid", result_valid, 1);
`ifdef MOD_QUOTIENT_EN
    check("dz quotient", quotient, 0);
`endif

    // Exact division with one extra subtract: no wrap below zero
    load(8'd20, 8'd5, 1'b0);
    check("exact div_zero", div_zero, 0);
    sub_n(3);
    check("exact x_mid", x, 0);
    sub_n(2);
    check("exact x_end", x, 1);
    capture();
    check("exact result", result, 0);
`ifdef MOD_QUOTIENT_EN
    check("exact quotient", quotient, 4);
`endif

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].rem, vecs[i].quo, vecs[i].dz);
    end

    // Load with re high aborts: valid drops, old result kept, re ignored
    load(8'd100, 8'd7, 1'b1);
    check("abort result_valid", result_valid, 0);
    check("abort result_kept", result, 2);
    check("abort x", x, 0);
    sub_n(5);
    check("midop x", x, 0);
    #3 reset = 1'b1;
    #1;
    check("async result", result, 0);
    check("async result_valid", result_valid, 0);
    check("async div_zero", div_zero, 0);
    check("async x", x, 1);
    @(negedge CLK);
    reset = 1'b0;
    run_op("reload", 8'd9, 8'd4, 8'd1, 8'd2, 1'b0);

    for (int k = 0; k < 20; k++) begin
      logic [W-1:0] ra, rb, rrem, rquo;
      ra = W'($urandom);
      rb = (k % 5 == 0) ? '0 : W'($urandom_range(1, 40));
      rrem = (rb == 0) ? ra : W'(int'(ra) % int'(rb));
      rquo = (rb == 0) ? '0 : W'(int'(ra) / int'(rb));
      run_op($sformatf("rand%0d a=%0d b=%0d", k, ra, rb), ra, rb, rrem, rquo, rb == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
